// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide engine.
//   - funct codes of the four multiply/divide instructions
//   - FSM state encoding (also exposed on the interface for observation)
//   - data width / divide iteration count
//   - helpers: multiply/divide funct decode, conditional absolute value
package mult_div_unit_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = 32;  // one quotient bit per cycle, equal to XLEN

  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  function automatic logic is_md(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  // Magnitude of v when it is treated as signed, otherwise v unchanged.
  // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                               input logic             is_signed);
    return (is_signed && v[XLEN-1]) ? (XLEN'(0) - v) : v;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Bundle between the EX stage and the multiply/divide engine.
//   funct, operand_1, operand_2 : EX-stage instruction fields
//   flush                       : abort whatever is in flight
//   hold                        : EX frozen by another stall source
//   mult_div_done               : result valid (registered)
//   mult_div_result             : {hi, lo}
//   state                       : current engine state, for observation
//
// Handshake: mult_div_done acts as valid and !hold as ready. The result is
// transferred in a cycle where mult_div_done=1 and hold=0; while hold=1 the
// engine keeps mult_div_done=1 and mult_div_result unchanged. flush drops any
// operation, including a presented but not yet consumed result.
interface mult_div_unit_if;
  import mult_div_unit_pkg::*;

  logic [5:0]      funct;
  logic [XLEN-1:0] operand_1;
  logic [XLEN-1:0] operand_2;
  logic            flush;
  logic            hold;
  logic            mult_div_done;
  logic [63:0]     mult_div_result;
  md_state_e       state;

  modport master (
    output funct, operand_1, operand_2, flush, hold,
    input  mult_div_done, mult_div_result, state
  );

  modport slave (
    input  funct, operand_1, operand_2, flush, hold,
    output mult_div_done, mult_div_result, state
  );

endinterface

// File: rtl/mult_div_unit_div_core.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
//   clk, rst          : clock, asynchronous active-low reset
//   start_i           : load dividend/divisor, clear remainder and counter
//   step_i            : perform one iteration
//   dividend_abs_i    : dividend magnitude
//   divisor_abs_i     : divisor magnitude (non-zero)
//   quotient_o        : quotient after the final step
//   remainder_o       : remainder after the final step
//   last_iter_o       : the step taken this cycle is the final one
module mult_div_unit_div_core
  import mult_div_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_abs_i,
  input  logic [XLEN-1:0] divisor_abs_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            last_iter_o
);

  localparam int CNT_W = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

  // quo_q starts as the dividend; each step shifts its MSB into the partial
  // remainder and shifts the new quotient bit in at the bottom.
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0]    rem_shift;   // 33-bit partial remainder
  logic [XLEN:0]    diff;
  logic             borrow;

  // rem_shift < 2*divisor, so a non-negative difference always fits in 32
  // bits and bit 32 of the 33-bit difference is exactly the borrow.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, div_q};
    borrow    = diff[XLEN];
    rem_d     = borrow ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];
    quo_d     = {quo_q[XLEN-2:0], ~borrow};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      rem_q <= '0;
      quo_q <= dividend_abs_i;
      div_q <= divisor_abs_i;
      cnt_q <= '0;
    end else if (step_i) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign last_iter_o = step_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide engine beside the EX stage.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   md   : slave side of mult_div_unit_if (funct/operands/flush/hold in,
//          mult_div_done/mult_div_result/state out)
// MULT/MULTU finish in cycle 2, DIV/DIVU in cycle 34 and divide by zero in
// cycle 1, counting the cycle the instruction is first seen as cycle 0.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input logic            clk,
  input logic            rst,
  mult_div_unit_if.slave md
);

  md_state_e       state_q, state_d;
  logic            sign_a_q, sign_a_d;   // dividend/multiplicand negative (signed ops only)
  logic            sign_b_q, sign_b_d;
  logic [XLEN-1:0] a_abs_q, a_abs_d;
  logic [XLEN-1:0] b_abs_q, b_abs_d;
  logic [63:0]     result_q, result_d;

  logic            op_signed;
  logic            op_mul;
  logic [XLEN-1:0] op_a_abs;
  logic [XLEN-1:0] op_b_abs;

  logic            div_start;
  logic            div_step;
  logic            div_last;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;

  logic [63:0]     mag;
  logic [63:0]     product;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  assign op_signed = (md.funct == FUNCT_MULT) || (md.funct == FUNCT_DIV);
  assign op_mul    = (md.funct == FUNCT_MULT) || (md.funct == FUNCT_MULTU);
  assign op_a_abs  = abs_val(md.operand_1, op_signed);
  assign op_b_abs  = abs_val(md.operand_2, op_signed);

  mult_div_unit_div_core u_div_core (
    .clk            (clk),
    .rst            (rst),
    .start_i        (div_start),
    .step_i         (div_step),
    .dividend_abs_i (op_a_abs),
    .divisor_abs_i  (op_b_abs),
    .quotient_o     (div_quo),
    .remainder_o    (div_rem),
    .last_iter_o    (div_last)
  );

  // Sign bits are only set for signed ops, so unsigned ops never negate.
  always_comb begin
    mag     = {32'd0, a_abs_q} * {32'd0, b_abs_q};
    product = (sign_a_q ^ sign_b_q) ? (64'd0 - mag) : mag;
    quo_fix = (sign_a_q ^ sign_b_q) ? (XLEN'(0) - div_quo) : div_quo;
    rem_fix = sign_a_q ? (XLEN'(0) - div_rem) : div_rem;
  end

  always_comb begin
    state_d   = state_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    a_abs_d   = a_abs_q;
    b_abs_d   = b_abs_q;
    result_d  = result_q;
    div_start = 1'b0;
    div_step  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_md(md.funct) && !md.flush) begin
          sign_a_d = op_signed & md.operand_1[XLEN-1];
          sign_b_d = op_signed & md.operand_2[XLEN-1];
          a_abs_d  = op_a_abs;
          b_abs_d  = op_b_abs;
          if (op_mul) begin
            state_d = ST_MUL;
          end else if (md.operand_2 == '0) begin
            // Defined divide-by-zero value, independent of signedness.
            state_d  = ST_DONE;
            result_d = {md.operand_1, 32'hFFFF_FFFF};
          end else begin
            state_d   = ST_DIV;
            div_start = 1'b1;
          end
        end
      end
      ST_MUL: begin
        result_d = product;
        state_d  = ST_DONE;
      end
      ST_DIV: begin
        div_step = 1'b1;
        if (div_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = {rem_fix, quo_fix};
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (!md.hold) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush wins over everything; the last presented result is kept.
    if (md.flush) begin
      state_d   = ST_IDLE;
      result_d  = result_q;
      div_start = 1'b0;
      div_step  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_abs_q  <= '0;
      b_abs_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_abs_q  <= a_abs_d;
      b_abs_q  <= b_abs_d;
      result_q <= result_d;
    end
  end

  assign md.mult_div_done   = (state_q == ST_DONE);
  assign md.mult_div_result = result_q;
  assign md.state           = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal results,
// randomized operations checked against an arithmetic model, flush and
// asynchronous reset scenarios.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int HUGE = 1 << 30;

  logic clk;
  logic rst;
  mult_div_unit_if md();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .md  (md.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model_res = '0;   // value the result register must hold
  int          busy_from = HUGE; // result may change in [busy_from, done_from)
  int          done_from = HUGE; // done expected in [done_from, done_to]
  int          done_to   = -1;
  bit          cmp_en    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (f == FUNCT_MULT)  return 64'(sa * sb);
    if (f == FUNCT_MULTU) return ua * ub;
    if (b == 32'd0)       return {a, 32'hFFFF_FFFF};
    if (f == FUNCT_DIV) begin
      q = sa / sb;   // truncates toward zero; remainder follows dividend sign
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  function automatic int latency(input logic [5:0] f, input logic [31:0] b);
    if (f == FUNCT_MULT || f == FUNCT_MULTU) return 2;
    if (b == 32'd0) return 1;
    return 34;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      chk("done", 64'(md.mult_div_done), 64'(cyc >= done_from && cyc <= done_to));
      if (cyc == done_from) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL exp_q (cycle %0d): got empty expected an entry", cyc);
        end else begin
          model_res = exp_q.pop_front();
        end
      end
      if (!(cyc >= busy_from && cyc < done_from))
        chk("result", md.mult_div_result, model_res);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold_n, input bit rand_ops);
    int k, lat;
    lat = latency(f, b);
    @(negedge clk); #1;
    k            = cyc;
    md.funct     = f;
    md.operand_1 = a;
    md.operand_2 = b;
    md.flush     = 1'b0;
    md.hold      = 1'b0;
    exp_q.push_back(model(f, a, b));
    busy_from = k;
    done_from = k + lat;
    done_to   = k + lat + hold_n;
    for (int c = k + 1; c <= k + lat + hold_n; c++) begin
      @(negedge clk); #1;
      if (c < k + lat && rand_ops) begin
        md.operand_1 = $urandom;
        md.operand_2 = $urandom;
      end
      if (c == k + lat && hold_n > 0) md.hold = 1'b1;
      if (c == k + lat + hold_n) begin
        md.hold  = 1'b0;
        md.funct = 6'h00;
      end
    end
  endtask

  task automatic run_flush(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                           input int fc);
    int k;
    @(negedge clk); #1;
    k = cyc;
    busy_from = HUGE;
    done_from = HUGE;
    done_to   = -1;
    md.funct     = f;
    md.operand_1 = a;
    md.operand_2 = b;
    md.flush     = (fc == 0);
    for (int c = k + 1; c <= k + fc; c++) begin
      @(negedge clk); #1;
      if (c == k + fc) md.flush = 1'b1;
    end
    @(negedge clk); #1;
    md.flush = 1'b0;
    md.funct = 6'h00;
    chk("flush_state", 64'(md.state), 64'(ST_IDLE));
  endtask

  task automatic idle_cycles(input int n);
    logic [5:0] f;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      do f = 6'($urandom_range(0, 63)); while (is_md(f));
      md.funct     = f;
      md.operand_1 = $urandom;
      md.operand_2 = $urandom;
    end
    @(negedge clk); #1;
    md.funct = 6'h00;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  logic [5:0] md_codes[4];

  initial begin
    md_codes = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    rst          = 1'b0;
    md.funct     = 6'h00;
    md.operand_1 = '0;
    md.operand_2 = '0;
    md.flush     = 1'b0;
    md.hold      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done",   64'(md.mult_div_done), 64'd0);
    chk("rst_result", md.mult_div_result, 64'd0);
    chk("rst_state",  64'(md.state), 64'(ST_IDLE));
    #1;
    rst    = 1'b1;
    cmp_en = 1'b1;

    // Directed cases with literal results.
    run_op(FUNCT_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 0, 1'b0);
    chk("lit_mult", md.mult_div_result, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b1);
    chk("lit_multu", md.mult_div_result, 64'hFFFF_FFFE_0000_0001);
    run_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b1);
    chk("lit_div_neg", md.mult_div_result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(FUNCT_DIVU, 32'd100, 32'd7, 0, 1'b0);
    chk("lit_divu", md.mult_div_result, 64'h0000_0002_0000_000E);
    run_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    chk("lit_div_ovf", md.mult_div_result, 64'h0000_0000_8000_0000);
    run_op(FUNCT_DIVU, 32'd5, 32'd0, 0, 1'b0);
    chk("lit_div0", md.mult_div_result, 64'h0000_0005_FFFF_FFFF);

    // Flush mid-divide, then a multiply right after.
    run_flush(FUNCT_DIVU, 32'd1000, 32'd3, 10);
    idle_cycles(3);
    run_op(FUNCT_MULTU, 32'd2, 32'd3, 0, 1'b0);
    chk("lit_after_flush", md.mult_div_result, 64'd6);

    // Flush in IDLE suppresses the start.
    run_flush(FUNCT_MULT, 32'd7, 32'd9, 0);
    idle_cycles(2);

    // Result held while hold=1, no restart, then IDLE.
    run_op(FUNCT_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 3, 1'b0);
    chk("lit_hold", md.mult_div_result, 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clk); #1;
    chk("hold_exit_state", 64'(md.state), 64'(ST_IDLE));

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      run_op(md_codes[$urandom_range(0, 3)], pick(), pick(),
             int'($urandom_range(0, 2)), 1'b1);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    // Asynchronous reset in the middle of a divide.
    @(negedge clk); #1;
    busy_from    = HUGE;
    done_from    = HUGE;
    done_to      = -1;
    md.funct     = FUNCT_DIVU;
    md.operand_1 = 32'd1000;
    md.operand_2 = 32'd7;
    repeat (15) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    model_res = '0;
    exp_q.delete();
    chk("async_rst_done",   64'(md.mult_div_done), 64'd0);
    chk("async_rst_result", md.mult_div_result, 64'd0);
    chk("async_rst_state",  64'(md.state), 64'(ST_IDLE));
    @(negedge clk); #1;
    rst      = 1'b1;
    md.funct = 6'h00;
    run_op(FUNCT_DIVU, 32'd9, 32'd3, 0, 1'b0);
    chk("lit_after_rst", md.mult_div_result, 64'h0000_0000_0000_0003);
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide engine beside the EX stage.
- Watches the EX-stage funct and operands, runs MULT/MULTU/DIV/DIVU, and returns a 64-bit {hi, lo} result with a done flag.
- EX holds its stall request while a multiply/divide funct is present and done is low, then writes HI/LO from the result.
- Holds the result stable until the pipeline consumes it.

Parameters:
- DIV_ITERS, 32, restoring-divide iterations (one quotient bit per cycle); fixed to the data width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- funct  in  6  EX-stage funct field (FUNCT_BUS)
- operand_1  in  32  rs value: multiplicand / dividend
- operand_2  in  32  rt value: multiplier / divisor
- flush  in  1  pipeline flush (exception/eret); aborts any operation
- hold  in  1  EX frozen by a stall from another source (e.g. MEM); keeps the result presented
- mult_div_done  out  1  result valid this cycle (registered)
- mult_div_result  out  64  {hi, lo} (MULT_DIV_BUS): product, or {remainder, quotient}

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, mult_div_done=0, mult_div_result=0, all internal registers 0.
- Op decode: is_md = funct in {MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B}.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - If is_md and !flush: latch funct and operands (signed ops store absolute values plus sign bits).
  - MULT/MULTU → MUL.
  - DIV/DIVU with operand_2==0 → DONE, result={operand_1, 32'hFFFFFFFF} (defined divide-by-zero value, both signednesses).
  - Other DIV/DIVU → DIV with iteration counter=0.
- MUL: one cycle; 64-bit product of the latched operands, signed for MULT and unsigned for MULTU. Result registered, then → DONE.
- DIV: restoring divide on 32-bit magnitudes, one bit per cycle.
  - Partial remainder is 33 bits; shift in the next dividend bit; subtract the divisor if no borrow; set the quotient bit.
  - Counter 0..31; after iteration 31 → FIX.
- FIX: one cycle.
  - Signed DIV: negate the quotient if the operand signs differ; the remainder takes the dividend's sign.
  - DIVU: pass through unchanged.
  - Register result={rem, quo}, then → DONE.
- DONE:
  - mult_div_done=1.
  - If hold=1, stay in DONE with the result stable.
  - Otherwise → IDLE next cycle.
  - A following mult/div instruction is seen in IDLE one cycle later; there is no same-cycle restart.
- Latency, counting the cycle the op is first seen as cycle 0:
  - MULT/MULTU: done in cycle 2.
  - DIV/DIVU: done in cycle 34.
  - Divide by zero: done in cycle 1.
- mult_div_done is 0 in every state except DONE.
- mult_div_result keeps its last value outside DONE and is not cleared on flush.
- flush=1 in any state:
  - Next state is IDLE and mult_div_done=0 next cycle.
  - In IDLE, flush suppresses the start.
- Operands are sampled only in IDLE. Changes during MUL/DIV/FIX are ignored.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0. No trap.
- Non-md funct in IDLE: remain IDLE, done=0.

Decomposition:
- funct.v: FUNCT_MULT/MULTU/DIV/DIVU codes are already shared.
- bus.v: add the state encoding macros beside MULT_DIV_BUS (existing).
- Sub-module div_core: 33-bit restoring iteration datapath.
  - Inputs: start, dividend_abs, divisor_abs.
  - Outputs: quotient, remainder, last_iter.
- mult_div_unit keeps the FSM, sign handling and the multiply.

Test Plan:
- MULT 0xFFFFFFFD × 0x00000005 → done=1 in cycle 2 only; result 0xFFFFFFFF_FFFFFFF1.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE_00000001, done in cycle 2.
- DIV 0xFFFFFFF9 (−7) / 2 → done in cycle 34; hi 0xFFFFFFFF, lo 0xFFFFFFFD.
- DIVU 100/7 → result {0x2, 0xE}.
- DIV 0x80000000 / 0xFFFFFFFF → {0x0, 0x80000000}.
- DIVU 5/0 → done in cycle 1, result {0x5, 0xFFFFFFFF}.
- DIVU started, flush=1 in cycle 10 → done stays 0, state IDLE. Then MULTU 2×3 → done in cycle 2, result 0x6.
- MULT completes with hold=1 for 3 cycles → done stays 1 with the result stable for 3+1 cycles and no restart; after hold drops → IDLE.
- rst=0 asynchronously mid-DIV (between clock edges) → done and result go to 0 immediately. After release with funct=DIVU 9/3 → result {0, 3} in cycle 34.
